// File: rtl/ibus_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// ibus_mem_responder_pkg : shared instruction-bus request/response types
// Revision: 1.0
// ============================================================================
package ibus_mem_responder_pkg;

  localparam int unsigned IBUS_ADDR_W = 32;
  localparam int unsigned IBUS_DATA_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [IBUS_ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic                   addr_ok;
    logic                   data_ok;
    logic [IBUS_DATA_W-1:0] data;
  } ibus_resp_t;

endpackage
`default_nettype wire

// File: rtl/ibus_mem_responder.sv
`default_nettype none
// ============================================================================
// ibus_mem_responder : in-order pipelined instruction read port with flush drop
// Revision: 1.0
// ============================================================================
module ibus_mem_responder
  import ibus_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = IBUS_ADDR_W,
  parameter int unsigned DATA_W  = IBUS_DATA_W,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  ibus_req_t         imem_req,
  output ibus_resp_t        imem_resp,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              resp_v_q, resp_v_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic w_full;
  logic w_accept;
  logic w_beat;

  // A returning beat frees its slot in the same cycle, so full only blocks
  // when nothing is coming back.
  assign w_full   = (cnt_q == CNT_W'(MAX_OUT)) && !mem_rvalid;
  assign mem_req  = imem_req.valid && !w_full && !flush && !reset;
  assign mem_addr = ADDR_W'(imem_req.addr);
  assign w_accept = mem_req && mem_gnt;
  assign w_beat   = mem_rvalid && (cnt_q != '0);

  always_comb begin
    imem_resp         = '0;
    imem_resp.addr_ok = w_accept;
    imem_resp.data_ok = resp_v_q && !flush;
    imem_resp.data    = IBUS_DATA_W'(resp_data_q);
  end

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(w_accept) - CNT_W'(w_beat);
    drop_d      = drop_q;
    resp_v_d    = 1'b0;
    resp_data_d = resp_data_q;
    if (flush) begin
      drop_d = cnt_q - CNT_W'(w_beat);
    end else if (w_beat) begin
      if (drop_q == '0) begin
        resp_v_d    = 1'b1;
        resp_data_d = mem_rdata;
      end else begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      drop_q      <= '0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
    end
  end

`ifndef SYNTHESIS
  a_drop_le_cnt: assert property (@(posedge clk) disable iff (reset) drop_q <= cnt_q)
    else $error("drop count exceeds outstanding count");
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (reset) mem_rvalid |-> (cnt_q != '0))
    else $error("mem_rvalid with no outstanding read");
  a_no_data_ok_on_flush: assert property (@(posedge clk) disable iff (reset) flush |-> !imem_resp.data_ok)
    else $error("data_ok asserted during flush");
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibus_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_ibus_mem_responder : directed + random scoreboard bench for the responder
// Revision: 1.0
// ============================================================================
module tb_ibus_mem_responder;
  import ibus_mem_responder_pkg::*;

  localparam int MAX_OUT = 4;

  typedef struct { logic [31:0] addr; bit stale; } out_t;
  typedef struct { logic [63:0] data; int unsigned cyc; } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  ibus_req_t   imem_req = '0;
  ibus_resp_t  imem_resp;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  ibus_mem_responder #(.ADDR_W(32), .DATA_W(64), .MAX_OUT(MAX_OUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_resp  (imem_resp),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  int   dok = 0;
  out_t outq[$];
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever data_ok is seen, flags stale or late beats.
  always @(negedge clk) begin
    #3;
    if (!reset) begin
      if (imem_resp.data_ok) begin
        dok++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_data_ok: got data_ok=1 data=%h expected no response", imem_resp.data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_data", imem_resp.data, mon_e.data);
          chk("resp_latency", 64'(cyc), 64'(mon_e.cyc + 1));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc + 1 <= cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_data_ok: got data_ok=0 expected data %h", mon_e.data);
      end
    end
  end

  // One bus cycle: drive, check the combinational handshake, update the reference model.
  task automatic drive(input logic v, input logic [31:0] a, input logic fl, input logic g,
                       input logic rv, input logic [63:0] rd, output logic acc);
    logic exp_req;
    logic exp_ack;
    out_t e;
    @(negedge clk);
    imem_req.valid = v;
    imem_req.addr  = a;
    flush          = fl;
    mem_gnt        = g;
    mem_rvalid     = rv;
    mem_rdata      = rd;
    #1;
    exp_req = v && !fl && !((outq.size() == MAX_OUT) && !rv);
    exp_ack = exp_req && g;
    chk("mem_req", 64'(mem_req), 64'(exp_req));
    chk("addr_ok", 64'(imem_resp.addr_ok), 64'(exp_ack));
    if (v) chk("mem_addr", 64'(mem_addr), 64'(a));
    if (fl && exp_q.size() > 0 && exp_q[$].cyc + 1 == cyc) void'(exp_q.pop_back());
    if (rv) begin
      if (outq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bench_rvalid: got rvalid with %0d outstanding expected >0", outq.size());
      end else begin
        e = outq.pop_front();
        if (!e.stale && !fl) exp_q.push_back('{data: rd, cyc: cyc});
      end
    end
    if (fl) foreach (outq[i]) outq[i].stale = 1'b1;
    if (exp_ack) outq.push_back('{addr: a, stale: 1'b0});
    acc = exp_ack;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, acc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   d0;
    int   acc_n;
    int   budget;
    logic v;
    logic fl;
    logic rv;
    logic [31:0] a;
    logic [63:0] rd;

    // Reset values
    #1;
    chk("rst_addr_ok", 64'(imem_resp.addr_ok), 64'h0);
    chk("rst_data_ok", 64'(imem_resp.data_ok), 64'h0);
    chk("rst_data", imem_resp.data, 64'h0);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single read
    drive(1'b1, 32'h1FC0_0000, 1'b0, 1'b1, 1'b0, 64'h0, acc);
    chk("t1_addr_ok", 64'(imem_resp.addr_ok), 64'h1);
    idle(1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, acc);
    idle(1);
    chk("t1_data_ok", 64'(imem_resp.data_ok), 64'h1);
    chk("t1_data", imem_resp.data, 64'hDEAD_BEEF_0000_0001);
    idle(1);
    chk("t1_cnt", 64'(dut.cnt_q), 64'h0);

    // Fill to MAX_OUT, then a returning beat lets the 5th in during the same cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h2000 + 32'(8 * i), 1'b0, 1'b1, 1'b0, 64'h0, acc);
      chk("t2_addr_ok_fill", 64'(imem_resp.addr_ok), 64'h1);
    end
    drive(1'b1, 32'h2020, 1'b0, 1'b1, 1'b0, 64'h0, acc);
    chk("t2_addr_ok_full", 64'(imem_resp.addr_ok), 64'h0);
    chk("t2_mem_req_full", 64'(mem_req), 64'h0);
    drive(1'b1, 32'h2020, 1'b0, 1'b1, 1'b1, 64'h1111_0000_0000_2000, acc);
    chk("t2_addr_ok_rvalid", 64'(imem_resp.addr_ok), 64'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h1111_0000_0000_2008, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h1111_0000_0000_2010, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h1111_0000_0000_2018, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h1111_0000_0000_2020, acc);
    idle(2);

    // Flush with 3 outstanding, then a new request right after
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h3000 + 32'(8 * i), 1'b0, 1'b1, 1'b0, 64'h0, acc);
    drive(1'b1, 32'h3018, 1'b1, 1'b1, 1'b0, 64'h0, acc);
    chk("t3_addr_ok_flush", 64'(imem_resp.addr_ok), 64'h0);
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 64'h0, acc);
    chk("t3_addr_ok_after", 64'(imem_resp.addr_ok), 64'h1);
    d0 = dok;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h0000_0BAD_0000_3000, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h0000_0BAD_0000_3008, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h0000_0BAD_0000_3010, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h0000_0100_0000_0100, acc);
    idle(2);
    chk("t3_dok_count", 64'(dok - d0), 64'h1);
    chk("t3_data_hold", imem_resp.data, 64'h0000_0100_0000_0100);

    // Flush coinciding with rvalid while a kept response is registered
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h4000 + 32'(8 * i), 1'b0, 1'b1, 1'b0, 64'h0, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h4444_0000_0000_0001, acc);
    d0 = dok;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 64'h4444_0000_0000_0002, acc);
    chk("t4_data_ok_flush", 64'(imem_resp.data_ok), 64'h0);
    chk("t4_data_hold", imem_resp.data, 64'h4444_0000_0000_0001);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h4444_0000_0000_0003, acc);
    chk("t4_drop", 64'(dut.drop_q), 64'h1);
    idle(2);
    chk("t4_dok_count", 64'(dok - d0), 64'h0);
    drive(1'b1, 32'h4100, 1'b0, 1'b1, 1'b0, 64'h0, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h4444_0000_0000_4100, acc);
    idle(1);
    chk("t4_fresh_data_ok", 64'(imem_resp.data_ok), 64'h1);
    idle(1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h5000 + 32'(8 * i), 1'b0, 1'b1, 1'b0, 64'h0, acc);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h5555_AAAA_5555_AAAA, acc);
    @(negedge clk);
    imem_req.valid = 1'b1;
    imem_req.addr  = 32'h5100;
    mem_gnt        = 1'b1;
    mem_rvalid     = 1'b0;
    flush          = 1'b0;
    #1;
    chk("t5_data_ok_pre", 64'(imem_resp.data_ok), 64'h1);
    chk("t5_data_pre", imem_resp.data, 64'h5555_AAAA_5555_AAAA);
    reset = 1'b1;
    #1;
    chk("t5_rst_data_ok", 64'(imem_resp.data_ok), 64'h0);
    chk("t5_rst_data", imem_resp.data, 64'h0);
    chk("t5_rst_addr_ok", 64'(imem_resp.addr_ok), 64'h0);
    chk("t5_rst_mem_req", 64'(mem_req), 64'h0);
    exp_q.delete();
    outq.delete();
    imem_req = '0;
    mem_gnt  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h5200, 1'b0, 1'b1, 1'b0, 64'h0, acc);
    chk("t5_fresh_addr_ok", 64'(imem_resp.addr_ok), 64'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h5555_0000_0000_5200, acc);
    idle(1);
    chk("t5_fresh_data", imem_resp.data, 64'h5555_0000_0000_5200);
    idle(1);

    // Random grant/return latency with occasional flushes
    acc_n  = 0;
    budget = 0;
    v      = 1'b1;
    a      = $urandom;
    while (acc_n < 10000 && budget < 60000) begin
      fl = ($urandom_range(99) < 3);
      rv = (outq.size() > 0) && ($urandom_range(1) == 1);
      rd = rv ? {outq[0].addr, ~outq[0].addr} : 64'h0;
      drive(v, a, fl, ($urandom_range(9) < 7), rv, rd, acc);
      if (acc) begin
        acc_n++;
        v = ($urandom_range(3) != 0);
        a = $urandom;
      end else if (!v) begin
        v = ($urandom_range(1) == 1);
        a = $urandom;
      end
      budget++;
    end
    chk("rand_accepts_done", 64'(acc_n >= 10000), 64'h1);
    budget = 0;
    while (outq.size() > 0 && budget < 100) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, {outq[0].addr, ~outq[0].addr}, acc);
      budget++;
    end
    idle(3);
    chk("drain_outstanding", 64'(outq.size()), 64'h0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    chk("final_cnt", 64'(dut.cnt_q), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibus_mem_responder.md
# ibus_mem_responder

Responder end of the instruction bus: accepts `ibus_req_t` requests from the instruction-request mux and returns `ibus_resp_t` handshakes. It converts requests into an in-order, pipelined read port toward the instruction SRAM/cache array and tracks outstanding reads. On flush it silently discards responses still in flight, so fetch never sees a `data_ok` that belongs to a cancelled stream.

## Interface
- Parameters:
- `ADDR_W`, 32, request address width
- `DATA_W`, 64, fetch data width (two instructions)
- `MAX_OUT`, 4, maximum outstanding reads toward memory (≥1)
- Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `flush`  in  1  cancel every read not yet returned as `data_ok`
- `imem_req`  in  `ibus_req_t`  `{valid, addr[ADDR_W-1:0]}`
- `imem_resp`  out  `ibus_resp_t`  `{addr_ok, data_ok, data[DATA_W-1:0]}`
- `mem_req`  out  1  read request to memory
- `mem_addr`  out  ADDR_W  read address; equals `imem_req.addr`
- `mem_gnt`  in  1  memory accepts `mem_req` this cycle
- `mem_rvalid`  in  1  read data returned, strictly in request order
- `mem_rdata`  in  DATA_W  read data

## Operation
- State: `cnt` (reads issued, not yet returned; 0..MAX_OUT), `drop` (returning beats to discard; 0..cnt), `resp_v`/`resp_data` (registered response). Counter width `$clog2(MAX_OUT+1)`.
- `full = (cnt == MAX_OUT) && !mem_rvalid`. A returning beat frees its slot in the same cycle.
- `mem_req = imem_req.valid && !full && !flush`; `mem_addr = imem_req.addr`.
- `addr_ok = mem_req && mem_gnt`, combinational. An accept is a cycle where `addr_ok` = 1.
- Per cycle: `cnt_n = cnt + accept - mem_rvalid`.
- Beat with `drop == 0` is kept: `resp_v <= 1`, `resp_data <= mem_rdata`. Otherwise `drop--`, `resp_v <= 0`.
- No returning beat: `resp_v <= 0`.
- `data_ok = resp_v && !flush`; `data = resp_data`, which holds its last value when `data_ok` = 0.
- Flush cycle: no accept. Any beat returning in this cycle is discarded. Then `drop <= cnt - mem_rvalid`, i.e. every read still outstanding is marked for discard, and `resp_v <= 0`.
- Flush while `drop` > 0 (back-to-back flush): same rule, so `drop` = remaining `cnt` and never exceeds `cnt`.
- `mem_rvalid` with `cnt == 0` is a protocol violation. The beat is ignored, `cnt` does not underflow, and a simulation assertion fires.
- Reset mid-operation: `cnt`, `drop`, `resp_v` and `resp_data` clear to 0. Memory is reset on the same `reset`, so no beats from before reset return.

## Timing
- Reset values: `addr_ok` = 0, `data_ok` = 0, `data` = 0, `mem_req` = 0.
- Address phase is zero-latency: `addr_ok` in the same cycle as `valid && mem_gnt`.
- Response latency: `data_ok` exactly 1 cycle after the kept `mem_rvalid`.
- Throughput: 1 accept and 1 `data_ok` per cycle sustained.
- With `MAX_OUT` outstanding and `mem_rvalid` in the same cycle, a new accept is still allowed.
- Requester holds `valid`/`addr` until `addr_ok`. The responder never asserts `addr_ok` without `valid`.
- First request after a flush may be accepted in the cycle after `flush`.

## Structure
- `ibus_req_t` and `ibus_resp_t` live in the shared instruction-bus header. No new typedefs.
- Only localparam: `CNT_W`.
- No sub-module needed; a single always_ff for counters and response register plus combinational handshake.
- Assertions:
  - `drop <= cnt`
  - no `rvalid` when `cnt == 0`
  - `data_ok` never asserted in a flush cycle

## Test plan
- Reset then single read: valid, addr 0x1FC0_0000, `gnt`=1, `rvalid` 2 cycles later with 0xDEAD_BEEF_0000_0001 -> `addr_ok` same cycle; `data_ok` with that data one cycle after `rvalid`; `cnt` back to 0.
- Fill with MAX_OUT=4: 5 back-to-back requests, `rvalid` held low -> 4 accepts, 5th `addr_ok` = 0. Pulse `rvalid` -> 5th accepted in that same cycle.
- Flush with 3 outstanding: 3 accepts, then `flush`; next cycle request 0x100 -> the 3 old beats produce no `data_ok`; the 4th beat's data is returned with `data_ok`.
- Simultaneous flush and `rvalid` with 2 outstanding, plus registered `resp_v` -> `data_ok` suppressed in the flush cycle, `drop` = 1, next beat discarded.
- Reset asserted mid-stream (`cnt` = 2, `resp_v` = 1) -> outputs 0 immediately (asynchronous); after release a fresh read completes normally.
- Random `gnt`/`rvalid` latency over 10k requests with random flushes -> scoreboard sees in-order data, no stale `data_ok`, no assertion failures.
